pon_burst_timing_gen: RTL
=========================

Name: pon_burst_timing_gen

Overview:
Consumes the VIO-driven burst configuration (preamble length, burst length, burst period) and generates the upstream PON burst timing on the GT TX user clock. The block produces cycle-accurate preamble/payload/burst-active strobes, start/end pulses and a burst counter. The downstream PON framer and laser-enable logic use these outputs. Live configuration is shadowed at period boundaries, so VIO writes never tear a burst in progress.

Parameters:
CNT_WIDTH, 32, width of length/period inputs and internal period counter
MIN_PERIOD, 2, smallest accepted burst_period; smaller values are rejected as invalid

Ports:
hb0_gtwiz_userclk_tx_usrclk2_int  input  1  sole clock (GT TX usrclk2)
hb0_gtwiz_userclk_tx_reset_int  input  1  synchronous active-high reset
run_en  input  1  enable burst generation
preamble_length  input  CNT_WIDTH  preamble cycles per burst (0 allowed)
burst_length  input  CNT_WIDTH  payload cycles per burst (0 allowed)
burst_period  input  CNT_WIDTH  total cycles per period, including gap
preamble_valid  output  1  current cycle is a preamble cycle
payload_valid  output  1  current cycle is a payload cycle
burst_active  output  1  preamble_valid OR payload_valid (laser enable)
burst_start  output  1  1-cycle pulse on first active cycle of a burst
burst_end  output  1  1-cycle pulse on last active cycle of a burst
burst_count  output  32  completed bursts, wraps at 2^32
cfg_error  output  1  last sampled configuration was invalid
busy  output  1  a period is in progress (state != IDLE)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; shadow registers 0; counter 0.
- Validity check, using a CNT_WIDTH+1-bit sum: valid = (burst_period >= MIN_PERIOD) && (preamble_length + burst_length <= burst_period).
- States: IDLE, PREAMBLE, PAYLOAD, GAP. All outputs are registered.
- IDLE: when run_en=1, sample the config and check it.
  - Valid config: load shadows, clear cfg_error, set cnt=0, and go to PREAMBLE. If the preamble shadow is 0, go to PAYLOAD instead; if the burst shadow is also 0, go to GAP.
  - Invalid config: set cfg_error=1 and stay in IDLE. Re-check every cycle.
- Latency: run_en sampled high at edge N means the first period cycle (cnt=0) appears on outputs after edge N+1.
- Period segments, by cnt in period: [0, Lp) preamble_valid=1; [Lp, Lp+Lb) payload_valid=1; [Lp+Lb, P) gap, all strobes 0.
- burst_start: asserted with the cnt=0 cycle when Lp+Lb > 0.
- burst_end: asserted with the cycle at cnt=Lp+Lb-1. If Lp+Lb = 1, burst_start and burst_end fire in the same cycle.
- burst_count: increments by 1 in the cycle burst_end is high.
- Lp+Lb = 0: no strobes and no pulses for that period; the whole period is GAP.
- Lp+Lb = P: no gap cycles; the next period starts back-to-back.
- Period boundary (cnt=P-1):
  - If run_en=1 and live config is valid: reload shadows, set cnt=0, continue with no idle cycle.
  - If run_en=0: go to IDLE. run_en deasserting mid-period never truncates the burst; the current period completes.
  - If run_en=1 and config is invalid: set cfg_error=1 and go to IDLE.
- Changes to live config inputs mid-period have no effect until the next boundary.
- Reset asserted mid-burst: all strobes low on the next cycle. A partial burst does not count.

Decomposition:
- Package pon_burst_pkg holds:
  - state enum (IDLE, PREAMBLE, PAYLOAD, GAP)
  - CNT_WIDTH default
  - MIN_PERIOD default
- One sub-module, pon_burst_cfg_shadow, holds:
  - the combinational validity check
  - the load-enabled shadow registers for Lp/Lb/P
  - the cfg_error flag
- The top level holds the FSM, counter and pulse/count logic.

Test Plan:
- Lp=4, Lb=8, P=20, run_en held 1 for 3 periods:
  - preamble_valid on cycles 0-3, payload_valid on 4-11, gap on 12-19 of each period
  - burst_start at cnt 0, burst_end at cnt 11
  - burst_count = 3
- Lp=0, Lb=1, P=2: payload_valid alternates 1/0; burst_start and burst_end coincide every other cycle.
- Lp=5, Lb=6, P=10 (sum > P): outputs stay 0, cfg_error=1, busy=0. Changing P to 11 clears cfg_error and the burst starts 2 cycles after the change.
- Lp=2, Lb=3, P=8, change Lb to 5 at cnt 3: the current burst keeps Lb=3 (burst_end at cnt 4); the next period uses Lb=5 (burst_end at cnt 6).
- Drop run_en at cnt 1 of Lp=2, Lb=3, P=8: the period completes through cnt 7, then busy=0. Separately, assert reset at cnt 3: all outputs 0 next cycle and burst_count unchanged.
- Lp=0, Lb=0, P=4: busy=1 and no strobes or pulses; burst_count stays 0 across 5 periods.

Source files
------------

// File: rtl/pon_burst_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pon_burst_pkg : state encoding and default sizing for burst timing gen   |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
package pon_burst_pkg;

  localparam int DEF_CNT_WIDTH  = 32;
  localparam int DEF_MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_GAP      = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pon_burst_cfg_shadow.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pon_burst_cfg_shadow : live config check, period shadows, error flag     |
// | Revision             : 1.0                                               |
// +--------------------------------------------------------------------------+
module pon_burst_cfg_shadow
  import pon_burst_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample,
  input  logic [CNT_WIDTH-1:0] preamble_length,
  input  logic [CNT_WIDTH-1:0] burst_length,
  input  logic [CNT_WIDTH-1:0] burst_period,
  output logic                 cfg_valid,
  output logic [CNT_WIDTH-1:0] lp_q,
  output logic [CNT_WIDTH-1:0] lb_q,
  output logic [CNT_WIDTH-1:0] p_q,
  output logic                 cfg_error_q
);

  localparam logic [CNT_WIDTH-1:0] MIN_P = CNT_WIDTH'(MIN_PERIOD);

  logic [CNT_WIDTH:0]   sum_live;
  logic [CNT_WIDTH-1:0] lp_d;
  logic [CNT_WIDTH-1:0] lb_d;
  logic [CNT_WIDTH-1:0] p_d;
  logic                 cfg_error_d;

  always_comb begin
    // One extra bit so a wrapping Lp+Lb can never masquerade as fitting.
    sum_live    = {1'b0, preamble_length} + {1'b0, burst_length};
    cfg_valid   = (burst_period >= MIN_P) && (sum_live <= {1'b0, burst_period});
    lp_d        = lp_q;
    lb_d        = lb_q;
    p_d         = p_q;
    cfg_error_d = cfg_error_q;
    if (sample) begin
      cfg_error_d = !cfg_valid;
      if (cfg_valid) begin
        lp_d = preamble_length;
        lb_d = burst_length;
        p_d  = burst_period;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lp_q        <= '0;
      lb_q        <= '0;
      p_q         <= '0;
      cfg_error_q <= 1'b0;
    end else begin
      lp_q        <= lp_d;
      lb_q        <= lb_d;
      p_q         <= p_d;
      cfg_error_q <= cfg_error_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pon_burst_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pon_burst_timing_gen : upstream PON burst strobes, pulses and counter    |
// | Revision             : 1.0                                               |
// +--------------------------------------------------------------------------+
module pon_burst_timing_gen
  import pon_burst_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic                 hb0_gtwiz_userclk_tx_usrclk2_int,
  input  logic                 hb0_gtwiz_userclk_tx_reset_int,
  input  logic                 run_en,
  input  logic [CNT_WIDTH-1:0] preamble_length,
  input  logic [CNT_WIDTH-1:0] burst_length,
  input  logic [CNT_WIDTH-1:0] burst_period,
  output logic                 preamble_valid,
  output logic                 payload_valid,
  output logic                 burst_active,
  output logic                 burst_start,
  output logic                 burst_end,
  output logic [31:0]          burst_count,
  output logic                 cfg_error,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic clk;
  logic rst;
  assign clk = hb0_gtwiz_userclk_tx_usrclk2_int;
  assign rst = hb0_gtwiz_userclk_tx_reset_int;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] lp_sh, lb_sh, p_sh;
  logic [CNT_WIDTH:0]   sum_sh, cnt_nxt;
  logic                 cfg_valid, cfg_sample, at_boundary;

  logic preamble_valid_q, preamble_valid_d;
  logic payload_valid_q, payload_valid_d;
  logic burst_active_q, burst_active_d;
  logic burst_start_q, burst_start_d;
  logic burst_end_q, burst_end_d;
  logic busy_q, busy_d;
  logic [31:0] burst_count_q, burst_count_d;

  pon_burst_cfg_shadow #(
    .CNT_WIDTH  (CNT_WIDTH),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_cfg_shadow (
    .clk             (clk),
    .rst             (rst),
    .sample          (cfg_sample),
    .preamble_length (preamble_length),
    .burst_length    (burst_length),
    .burst_period    (burst_period),
    .cfg_valid       (cfg_valid),
    .lp_q            (lp_sh),
    .lb_q            (lb_sh),
    .p_q             (p_sh),
    .cfg_error_q     (cfg_error)
  );

  assign sum_sh      = {1'b0, lp_sh} + {1'b0, lb_sh};
  assign cnt_nxt     = {1'b0, cnt_q} + {1'b0, ONE};
  assign at_boundary = (state_q != ST_IDLE) && (cnt_q == p_sh - ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      preamble_valid_q <= 1'b0;
      payload_valid_q  <= 1'b0;
      burst_active_q   <= 1'b0;
      burst_start_q    <= 1'b0;
      burst_end_q      <= 1'b0;
      busy_q           <= 1'b0;
      burst_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      preamble_valid_q <= preamble_valid_d;
      payload_valid_q  <= payload_valid_d;
      burst_active_q   <= burst_active_d;
      burst_start_q    <= burst_start_d;
      burst_end_q      <= burst_end_d;
      busy_q           <= busy_d;
      burst_count_q    <= burst_count_d;
    end
  end

  // Config is only ever sampled in IDLE or on the last cycle of a period.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_sample = 1'b0;
    if ((state_q == ST_IDLE) || at_boundary) begin
      cfg_sample = run_en;
      cnt_d      = '0;
      if (!run_en || !cfg_valid) begin
        state_d = ST_IDLE;
      end else if (preamble_length != '0) begin
        state_d = ST_PREAMBLE;
      end else if (burst_length != '0) begin
        state_d = ST_PAYLOAD;
      end else begin
        state_d = ST_GAP;
      end
    end else begin
      cnt_d = cnt_q + ONE;
      if (cnt_nxt < {1'b0, lp_sh}) begin
        state_d = ST_PREAMBLE;
      end else if (cnt_nxt < sum_sh) begin
        state_d = ST_PAYLOAD;
      end else begin
        state_d = ST_GAP;
      end
    end
  end

  always_comb begin
    preamble_valid_d = (state_q == ST_PREAMBLE);
    payload_valid_d  = (state_q == ST_PAYLOAD);
    burst_active_d   = preamble_valid_d || payload_valid_d;
    burst_start_d    = burst_active_d && (cnt_q == '0);
    burst_end_d      = burst_active_d && (cnt_nxt == sum_sh);
    busy_d           = (state_q != ST_IDLE);
    burst_count_d    = burst_count_q;
    if (burst_end_d) begin
      burst_count_d = burst_count_q + 32'd1;
    end
  end

  assign preamble_valid = preamble_valid_q;
  assign payload_valid  = payload_valid_q;
  assign burst_active   = burst_active_q;
  assign burst_start    = burst_start_q;
  assign burst_end      = burst_end_q;
  assign busy           = busy_q;
  assign burst_count    = burst_count_q;

endmodule
`default_nettype wire
